// File: rtl/maxterm_pkg.sv
// maxterm_pkg
//   Shared definitions for the maxterm_sweeper truth-table generator:
//   sweep FSM state encoding, parameter limits and the Gray-code helper.
//   No ports (package).
//   Optional feature macro used by the top level: GRAY_SWEEP_EN.

package maxterm_pkg;

  localparam int N_MAX = 8;
  localparam int F_MAX = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Binary-reflected Gray code: adjacent values differ in exactly one bit.
  function automatic logic [N_MAX:0] to_gray(input logic [N_MAX:0] idx);
    return idx ^ (idx >> 1);
  endfunction

endpackage

// File: rtl/maxterm_lut.sv
// maxterm_lut
//   One programmable boolean function of N inputs stored as a 2^N-bit truth
//   table. Bit i of the table is the function value for input combination i;
//   its 0 bits are the maxterms. Reset clears the table (function = 0).
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high, clears the table
//   we    - load data into the table at the next edge
//   data  - new truth table (2^N bits)
//   addr  - input combination to evaluate (N bits)
//   q     - function value at addr (combinational)

module maxterm_lut #(
  parameter int N = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [(1<<N)-1:0]   data,
  input  logic [N-1:0]        addr,
  output logic                q
);

  logic [(1<<N)-1:0] tbl;

  always_ff @(posedge clk) begin
    if (reset) begin
      tbl <= '0;
    end else if (we) begin
      tbl <= data;
    end
  end

  assign q = tbl[addr];

endmodule

// File: rtl/maxterm_sweeper.sv
// maxterm_sweeper
//   Holds F truth tables of N inputs each and, on start, streams every input
//   combination once over a valid/ready interface: the input vector plus the
//   value of every function for that vector.
//   Optional feature: define GRAY_SWEEP_EN to sweep the rows in Gray-code order
//   (consecutive rows differ in one input bit); otherwise rows are binary order.
// Ports:
//   clk       - rising-edge clock
//   reset     - synchronous active-high; aborts a sweep and clears all tables
//   cfg_we    - write cfg_data into table cfg_sel (accepted in IDLE only)
//   cfg_sel   - function index; indices >= F are ignored
//   cfg_data  - truth table, bit i = f(row_in = i)
//   start     - begin a sweep (accepted in IDLE only, never queued)
//   busy      - sweep in progress
//   row_valid - a row is presented
//   row_ready - consumer accepts the presented row
//   row_in    - input combination, MSB = first variable
//   row_out   - bit f = table[f][row_in]
//   row_last  - presented row is the final one
//   done      - one-cycle pulse after the final row is accepted

module maxterm_sweeper
  import maxterm_pkg::*;
#(
  parameter  int N     = 3,
  parameter  int F     = 5,
  localparam int SEL_W = (F > 1) ? $clog2(F) : 1,
  localparam int ROWS  = 1 << N
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [SEL_W-1:0] cfg_sel,
  input  logic [ROWS-1:0]  cfg_data,
  input  logic             start,
  output logic             busy,
  output logic             row_valid,
  input  logic             row_ready,
  output logic [N-1:0]     row_in,
  output logic [F-1:0]     row_out,
  output logic             row_last,
  output logic             done
);

  if (N < 1 || N > N_MAX) begin : g_bad_n
    $error("maxterm_sweeper: N out of range");
  end
  if (F < 1 || F > F_MAX) begin : g_bad_f
    $error("maxterm_sweeper: F out of range");
  end

  localparam logic [N:0] LAST_IDX = (N+1)'(ROWS - 1);

  state_t     state;
  state_t     state_next;
  logic [N:0] idx;
  logic       at_last;
  logic       handshake;
  logic       cfg_open;

  assign at_last   = (idx == LAST_IDX);
  assign handshake = row_valid & row_ready;
  assign cfg_open  = cfg_we & (state == IDLE);

  // row_last is qualified by row_valid so that the counter parked at the
  // final index after a sweep does not flag a stale "last" while idle.
  assign row_last = row_valid & at_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (handshake && row_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    row_valid = 1'b0;
    done      = 1'b0;
    case (state)
      RUN:     begin busy = 1'b1; row_valid = 1'b1; end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // The index parks on the final row instead of wrapping; a new start
  // clears it on the way into RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
    end else if (state == IDLE && start) begin
      idx <= '0;
    end else if (handshake && !at_last) begin
      idx <= idx + 1'b1;
    end
  end

`ifdef GRAY_SWEEP_EN
  assign row_in = N'(to_gray((N_MAX+1)'(idx)));
`else
  assign row_in = idx[N-1:0];
`endif

  // Writes are gated to IDLE, so every table is frozen for the whole sweep
  // and row_out holds steady while a row waits for row_ready.
  for (genvar f = 0; f < F; f++) begin : g_lut
    maxterm_lut #(.N(N)) u_lut (
      .clk   (clk),
      .reset (reset),
      .we    (cfg_open && (cfg_sel == SEL_W'(f))),
      .data  (cfg_data),
      .addr  (row_in),
      .q     (row_out[f])
    );
  end

endmodule

// File: tb/tb_maxterm_sweeper.sv
// tb_maxterm_sweeper
//   Directed bench for maxterm_sweeper. A main instance (N=3, F=5) covers
//   reset, binary/Gray sweeps, backpressure, blocked configuration, start
//   during a sweep, reset mid-sweep; a second instance (N=1, F=1) covers the
//   smallest sweep. Expected values come from hand-written tables.

module tb_maxterm_sweeper;

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  logic       cfg_we = 1'b0;
  logic [2:0] cfg_sel = '0;
  logic [7:0] cfg_data = '0;
  logic       start = 1'b0;
  logic       row_ready = 1'b0;
  logic       busy, row_valid, row_last, done;
  logic [2:0] row_in;
  logic [4:0] row_out;

  logic       cfg_we_b = 1'b0;
  logic [0:0] cfg_sel_b = '0;
  logic [1:0] cfg_data_b = '0;
  logic       start_b = 1'b0;
  logic       row_ready_b = 1'b0;
  logic       busy_b, row_valid_b, row_last_b, done_b;
  logic [0:0] row_in_b;
  logic [0:0] row_out_b;

  int checks = 0;
  int failures = 0;

  logic [7:0] tbl_m [5];
  int         seq [8];

  always #5 clk = ~clk;

  maxterm_sweeper #(.N(3), .F(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_data  (cfg_data),
    .start     (start),
    .busy      (busy),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_in    (row_in),
    .row_out   (row_out),
    .row_last  (row_last),
    .done      (done)
  );

  maxterm_sweeper #(.N(1), .F(1)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .cfg_we    (cfg_we_b),
    .cfg_sel   (cfg_sel_b),
    .cfg_data  (cfg_data_b),
    .start     (start_b),
    .busy      (busy_b),
    .row_valid (row_valid_b),
    .row_ready (row_ready_b),
    .row_in    (row_in_b),
    .row_out   (row_out_b),
    .row_last  (row_last_b),
    .done      (done_b)
  );

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [4:0] model_out(input int ri);
    logic [4:0] m;
    for (int f = 0; f < 5; f++) m[f] = tbl_m[f][ri];
    return m;
  endfunction

  task automatic check_row(input string name, input int r);
    check_output($sformatf("%s.r%0d.busy", name, r), 32'(busy), 32'd1);
    check_output($sformatf("%s.r%0d.valid", name, r), 32'(row_valid), 32'd1);
    check_output($sformatf("%s.r%0d.row_in", name, r), 32'(row_in), 32'(seq[r]));
    check_output($sformatf("%s.r%0d.row_out", name, r), 32'(row_out), 32'(model_out(seq[r])));
    check_output($sformatf("%s.r%0d.last", name, r), 32'(row_last), 32'(r == 7));
    check_output($sformatf("%s.r%0d.done", name, r), 32'(done), 32'd0);
  endtask

  task automatic write_cfg(input logic [2:0] sel, input logic [7:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_data = data;
    step();
    cfg_we = 1'b0;
  endtask

  // Full sweep from IDLE. stall_row is held with row_ready low for stall_n
  // cycles; at inject_row a blocked write of 8'hFF to f0 and a stray start
  // are applied. cfg_with_start writes f0 in the same cycle as start.
  task automatic apply_stimulus(input string name, input int stall_row,
                                input int stall_n, input int inject_row,
                                input bit cfg_with_start,
                                input logic [7:0] cfg_val);
    int stall;
    start = 1'b1; row_ready = 1'b1;
    if (cfg_with_start) begin
      cfg_we = 1'b1; cfg_sel = 3'd0; cfg_data = cfg_val;
      tbl_m[0] = cfg_val;
    end
    step();
    start = 1'b0; cfg_we = 1'b0;
    for (int r = 0; r < 8; r++) begin
      stall = (r == stall_row) ? stall_n : 0;
      for (int s = 0; s <= stall; s++) begin
        row_ready = (s == stall);
        if (r == inject_row && s == 0) begin
          start = 1'b1; cfg_we = 1'b1; cfg_sel = 3'd0; cfg_data = 8'hFF;
        end
        check_row(name, r);
        step();
        start = 1'b0; cfg_we = 1'b0;
      end
    end
    row_ready = 1'b1;
    check_output({name, ".done_pulse"}, 32'(done), 32'd1);
    check_output({name, ".done_busy"}, 32'(busy), 32'd0);
    check_output({name, ".done_valid"}, 32'(row_valid), 32'd0);
    step();
    check_output({name, ".after_done"}, 32'(done), 32'd0);
    check_output({name, ".after_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
`ifdef GRAY_SWEEP_EN
    seq = '{0, 1, 3, 2, 6, 7, 5, 4};
`else
    seq = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
    for (int f = 0; f < 5; f++) tbl_m[f] = 8'h00;

    $display("[TB] reset");
    reset = 1'b1;
    step();
    step();
    check_output("rst.busy", 32'(busy), 32'd0);
    check_output("rst.valid", 32'(row_valid), 32'd0);
    check_output("rst.row_in", 32'(row_in), 32'd0);
    check_output("rst.row_out", 32'(row_out), 32'd0);
    check_output("rst.last", 32'(row_last), 32'd0);
    check_output("rst.done", 32'(done), 32'd0);
    reset = 1'b0;
    step();

    $display("[TB] load tables");
    write_cfg(3'd0, 8'h57); tbl_m[0] = 8'h57;
    write_cfg(3'd2, 8'h99); tbl_m[2] = 8'h99;
    write_cfg(3'd4, 8'hC3); tbl_m[4] = 8'hC3;
    write_cfg(3'd5, 8'hFF);
    write_cfg(3'd7, 8'hFF);
    check_output("idle.valid", 32'(row_valid), 32'd0);

    $display("[TB] plain sweep");
    apply_stimulus("s1", -1, 0, -1, 1'b0, 8'h00);

    $display("[TB] backpressure, blocked cfg and stray start");
    apply_stimulus("bp", 2, 3, 3, 1'b0, 8'h00);

    $display("[TB] sweep after blocked cfg");
    apply_stimulus("s2", -1, 0, 5, 1'b0, 8'h00);

    $display("[TB] cfg together with start");
    apply_stimulus("cs", -1, 0, -1, 1'b1, 8'hFF);

    $display("[TB] reset mid-sweep");
    start = 1'b1; row_ready = 1'b1;
    step();
    start = 1'b0;
    for (int r = 0; r < 4; r++) step();
    check_output("mid.row_in", 32'(row_in), 32'(seq[4]));
    reset = 1'b1;
    step();
    for (int f = 0; f < 5; f++) tbl_m[f] = 8'h00;
    check_output("mid.busy", 32'(busy), 32'd0);
    check_output("mid.valid", 32'(row_valid), 32'd0);
    check_output("mid.row_in", 32'(row_in), 32'd0);
    check_output("mid.row_out", 32'(row_out), 32'd0);
    check_output("mid.last", 32'(row_last), 32'd0);
    check_output("mid.done", 32'(done), 32'd0);
    reset = 1'b0;
    step();
    check_output("mid.nodone", 32'(done), 32'd0);
    step();
    check_output("mid.nodone2", 32'(done), 32'd0);
    apply_stimulus("clr", -1, 0, -1, 1'b0, 8'h00);

    $display("[TB] N=1 F=1");
    cfg_we_b = 1'b1; cfg_sel_b = 1'b0; cfg_data_b = 2'b10;
    step();
    cfg_we_b = 1'b0;
    start_b = 1'b1; row_ready_b = 1'b1;
    step();
    start_b = 1'b0;
    check_output("n1.r0.valid", 32'(row_valid_b), 32'd1);
    check_output("n1.r0.row_in", 32'(row_in_b), 32'd0);
    check_output("n1.r0.row_out", 32'(row_out_b), 32'd0);
    check_output("n1.r0.last", 32'(row_last_b), 32'd0);
    step();
    check_output("n1.r1.valid", 32'(row_valid_b), 32'd1);
    check_output("n1.r1.row_in", 32'(row_in_b), 32'd1);
    check_output("n1.r1.row_out", 32'(row_out_b), 32'd1);
    check_output("n1.r1.last", 32'(row_last_b), 32'd1);
    step();
    check_output("n1.done", 32'(done_b), 32'd1);
    check_output("n1.done_busy", 32'(busy_b), 32'd0);
    step();
    check_output("n1.after_done", 32'(done_b), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
